// File: rtl/spm_pkg.sv
// Shared sizing and state encoding for the sparse multiplier job sequencer.
package spm_pkg;

    localparam int N           = 1024;
    localparam int H           = 384;
    localparam int CORE_NUM    = 16;
    localparam int COEFF_WIDTH = 8;

    localparam int POLY_WORDS  = N;
    localparam int POS_DEPTH   = (H + CORE_NUM - 1) / CORE_NUM;
    localparam int POS_W       = $clog2(N);
    localparam int RES_WORDS   = N / 2;

    localparam int WORD_W      = 2 * COEFF_WIDTH;
    localparam int POS_WORD_W  = POS_W * CORE_NUM;
    localparam int POLY_AW     = $clog2(POLY_WORDS);
    localparam int POS_AW      = $clog2(POS_DEPTH);
    localparam int RES_AW      = $clog2(RES_WORDS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_POLY = 3'd1,
        LOAD_POS  = 3'd2,
        START     = 3'd3,
        WAIT      = 3'd4,
        DRAIN     = 3'd5
    } state_t;

endpackage

// File: rtl/spm_res_fifo2.sv
// Two-entry valid/ready FIFO decoupling the one-cycle-latency result RAM
// read from the downstream result stream. Head data is stable while stalled.
module spm_res_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;

    assign valid = (count != 2'd0);
    assign pop   = valid & ready;
    assign data  = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sparse_mul_job_ctrl.sv
// Job sequencer for sparse_mul_1024_384_16: loads poly/pos RAMs from
// valid/ready streams, pulses start, waits for done, drains results.
// Optional feature macro: SPM_CYCLE_CNT_EN adds a 32-bit cycle_cnt output
// measuring START through WAIT exit.
module sparse_mul_job_ctrl
    import spm_pkg::*;
#(
    parameter int GUARD_CYCLES = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_reuse,
    output logic                  cmd_ready,
    input  logic                  poly_valid,
    output logic                  poly_ready,
    input  logic [WORD_W-1:0]     poly_data,
    input  logic                  pos_valid,
    output logic                  pos_ready,
    input  logic [POS_WORD_W-1:0] pos_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WORD_W-1:0]     res_data,
    output logic                  busy,
    output logic                  mul_poly_wr_en,
    output logic [POLY_AW-1:0]    mul_poly_addr,
    output logic [WORD_W-1:0]     mul_poly_data,
    output logic                  mul_pos_wr_en,
    output logic [POS_AW-1:0]     mul_pos_addr,
    output logic [POS_WORD_W-1:0] mul_pos_data,
    output logic                  mul_start,
    input  logic                  mul_done,
    output logic                  mul_res_rd_en,
    output logic [RES_AW-1:0]     mul_res_rd_addr,
    input  logic [WORD_W-1:0]     mul_res_data
`ifdef SPM_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycle_cnt
`endif
);

    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    state_t               state;
    logic [GUARD_W-1:0]   guard_cnt;
    logic [POLY_AW-1:0]   poly_cnt;
    logic [POS_AW-1:0]    pos_cnt;
    logic [RES_AW:0]      rd_cnt;
    logic [RES_AW-1:0]    out_cnt;
    logic                 poly_loaded;
    logic                 rd_inflight;
    logic [1:0]           fifo_count;
    logic                 poly_hs;
    logic                 pos_hs;
    logic                 res_hs;
    logic [2:0]           pending;

    assign poly_ready      = (state == LOAD_POLY);
    assign pos_ready       = (state == LOAD_POS);
    assign poly_hs         = poly_valid & poly_ready;
    assign pos_hs          = pos_valid & pos_ready;

    assign mul_poly_wr_en  = poly_hs;
    assign mul_poly_addr   = poly_cnt;
    assign mul_poly_data   = poly_hs ? poly_data : '0;
    assign mul_pos_wr_en   = pos_hs;
    assign mul_pos_addr    = pos_cnt;
    assign mul_pos_data    = pos_hs ? pos_data : '0;

    assign mul_start       = (state == START);
    assign cmd_ready       = (state == IDLE) && (guard_cnt == '0);
    assign busy            = (state != IDLE) || (guard_cnt != '0);

    // Words that will occupy the FIFO after this cycle: stored + arriving - leaving.
    // Counting the pop keeps the read issue going every cycle when res_ready stays high.
    assign res_hs          = res_valid & res_ready;
    assign pending         = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, res_hs};
    assign mul_res_rd_en   = (state == DRAIN) && (rd_cnt < (RES_AW+1)'(RES_WORDS)) && (pending < 3'd2);
    assign mul_res_rd_addr = rd_cnt[RES_AW-1:0];

    spm_res_fifo2 #(.W(WORD_W)) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .push_data (mul_res_data),
        .ready     (res_ready),
        .valid     (res_valid),
        .data      (res_data),
        .count     (fifo_count)
    );

    // Job FSM, address counters, post-reset guard and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            guard_cnt   <= GUARD_W'(GUARD_CYCLES);
            poly_cnt    <= '0;
            pos_cnt     <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            poly_loaded <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            if (guard_cnt != '0) guard_cnt <= guard_cnt - 1'b1;
            rd_inflight <= mul_res_rd_en;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        poly_cnt <= '0;
                        pos_cnt  <= '0;
                        if (cmd_reuse && poly_loaded) begin
                            state <= LOAD_POS;
                        end else begin
                            // A partial reload leaves the RAM unusable for reuse.
                            poly_loaded <= 1'b0;
                            state       <= LOAD_POLY;
                        end
                    end
                end
                LOAD_POLY: begin
                    if (poly_hs) begin
                        if (poly_cnt == POLY_AW'(POLY_WORDS - 1)) begin
                            poly_cnt    <= '0;
                            poly_loaded <= 1'b1;
                            state       <= LOAD_POS;
                        end else begin
                            poly_cnt <= poly_cnt + 1'b1;
                        end
                    end
                end
                LOAD_POS: begin
                    if (pos_hs) begin
                        if (pos_cnt == POS_AW'(POS_DEPTH - 1)) begin
                            pos_cnt <= '0;
                            state   <= START;
                        end else begin
                            pos_cnt <= pos_cnt + 1'b1;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (mul_done) begin
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mul_res_rd_en) rd_cnt <= rd_cnt + 1'b1;
                    if (res_hs) begin
                        if (out_cnt == RES_AW'(RES_WORDS - 1)) begin
                            out_cnt <= '0;
                            rd_cnt  <= '0;
                            state   <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPM_CYCLE_CNT_EN
    // Multiplier run length: START cycle plus every WAIT cycle, held until the next START.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
        end else if (state == START) begin
            cycle_cnt <= 32'd1;
        end else if (state == WAIT) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sparse_mul_job_ctrl.sv
// Self-checking bench for sparse_mul_job_ctrl with a behavioural multiplier
// (done 30 cycles after start, result word j = {j[7:0], ~j[7:0]}).
module tb_sparse_mul_job_ctrl;
    import spm_pkg::*;

    localparam int GUARD = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_reuse = 1'b0;
    logic                  cmd_ready;
    logic                  poly_valid = 1'b0;
    logic                  poly_ready;
    logic [WORD_W-1:0]     poly_data = '0;
    logic                  pos_valid = 1'b0;
    logic                  pos_ready;
    logic [POS_WORD_W-1:0] pos_data = '0;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [WORD_W-1:0]     res_data;
    logic                  busy;
    logic                  mul_poly_wr_en;
    logic [POLY_AW-1:0]    mul_poly_addr;
    logic [WORD_W-1:0]     mul_poly_data;
    logic                  mul_pos_wr_en;
    logic [POS_AW-1:0]     mul_pos_addr;
    logic [POS_WORD_W-1:0] mul_pos_data;
    logic                  mul_start;
    logic                  mul_done = 1'b0;
    logic                  mul_res_rd_en;
    logic [RES_AW-1:0]     mul_res_rd_addr;
    logic [WORD_W-1:0]     mul_res_data = '0;
`ifdef SPM_CYCLE_CNT_EN
    logic [31:0]           cycle_cnt;
`endif

    sparse_mul_job_ctrl #(.GUARD_CYCLES(GUARD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_reuse(cmd_reuse), .cmd_ready(cmd_ready),
        .poly_valid(poly_valid), .poly_ready(poly_ready), .poly_data(poly_data),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_data(pos_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy),
        .mul_poly_wr_en(mul_poly_wr_en), .mul_poly_addr(mul_poly_addr), .mul_poly_data(mul_poly_data),
        .mul_pos_wr_en(mul_pos_wr_en), .mul_pos_addr(mul_pos_addr), .mul_pos_data(mul_pos_data),
        .mul_start(mul_start), .mul_done(mul_done),
        .mul_res_rd_en(mul_res_rd_en), .mul_res_rd_addr(mul_res_rd_addr), .mul_res_data(mul_res_data)
`ifdef SPM_CYCLE_CNT_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference stream contents.
    function automatic logic [WORD_W-1:0] poly_word(input int i);
        int hi;
        hi = (i + 1 == 512) ? 0 : (i + 1) % 251;
        return {8'(hi), 8'(i % 251)};
    endfunction

    function automatic logic [POS_WORD_W-1:0] pos_word(input int i);
        logic [POS_WORD_W-1:0] w;
        for (int k = 0; k < CORE_NUM; k++) w[k*POS_W +: POS_W] = POS_W'(i * CORE_NUM + k + 1);
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] res_word(input int j);
        logic [7:0] b;
        b = 8'(j);
        return {b, ~b};
    endfunction

    // Behavioural multiplier: RAMs, done timer and one-cycle result read.
    logic [WORD_W-1:0]     poly_ram [POLY_WORDS];
    logic [POS_WORD_W-1:0] pos_ram  [POS_DEPTH];
    int   dcnt = 0;
    logic stray_done = 1'b0;

    always @(posedge clk) begin
        if (mul_start) dcnt <= 29;
        else if (dcnt != 0) dcnt <= dcnt - 1;
        mul_done <= (dcnt == 1) || stray_done;
        if (mul_res_rd_en) mul_res_data <= res_word(int'(mul_res_rd_addr));
        if (mul_poly_wr_en) poly_ram[mul_poly_addr] <= mul_poly_data;
        if (mul_pos_wr_en) pos_ram[mul_pos_addr] <= mul_pos_data;
    end

    // Stimulus controls and bench-side transfer counters.
    logic drive_en = 1'b0;
    int   gap_pct = 0;
    int   rmode = 0;
    int   poly_idx = 0, pos_idx = 0, res_idx = 0;
    int   pw_cnt = 0, qw_cnt = 0, starts = 0, hold = 0;
    int   cyc = 0, first_acc = 0, last_acc = 0;
    bit   poly_ready_seen = 0;
    bit   stall_pending = 0;
    logic [WORD_W-1:0] stall_data = '0;

    // Drive stream inputs just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (drive_en) begin
            poly_valid = ($urandom_range(99) >= gap_pct);
            poly_data  = poly_word(poly_idx % POLY_WORDS);
            pos_valid  = ($urandom_range(99) >= gap_pct);
            pos_data   = pos_word(pos_idx % POS_DEPTH);
            case (rmode)
                0: res_ready = 1'b1;
                1: res_ready = ~res_ready;
                2: begin
                    if ((res_idx == 0 || res_idx == 256) && hold < 20) begin
                        res_ready = 1'b0;
                        if (res_valid) hold++;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                default: res_ready = ($urandom_range(1) == 1);
            endcase
        end else begin
            poly_valid = 1'b0;
            pos_valid  = 1'b0;
            res_ready  = 1'b0;
        end
    end

    // Sample mid-cycle: what is seen here is what the next rising edge transfers.
    always @(negedge clk) begin
        cyc++;
        if (poly_ready) poly_ready_seen = 1;
        if (mul_poly_wr_en) begin
            chk("poly_wr_needs_valid", 160'(poly_valid), 160'(1));
            chk("poly_wr_addr", 160'(mul_poly_addr), 160'(pw_cnt));
            chk("poly_wr_data", 160'(mul_poly_data), 160'(poly_word(pw_cnt)));
            pw_cnt++;
        end
        if (poly_valid && poly_ready) poly_idx++;
        if (mul_pos_wr_en) begin
            chk("pos_wr_addr", 160'(mul_pos_addr), 160'(qw_cnt));
            chk("pos_wr_data", mul_pos_data, pos_word(qw_cnt));
            qw_cnt++;
        end
        if (pos_valid && pos_ready) pos_idx++;
        if (mul_start) starts++;
        if (stall_pending && !rst) begin
            chk("res_hold_valid", 160'(res_valid), 160'(1));
            chk("res_hold_data", 160'(res_data), 160'(stall_data));
        end
        stall_pending = res_valid && !res_ready;
        stall_data    = res_data;
        if (res_valid && res_ready) begin
            chk("res_data", 160'(res_data), 160'(res_word(res_idx)));
            if (res_idx == 0) first_acc = cyc;
            last_acc = cyc;
            res_idx++;
            hold = 0;
        end
    end

    typedef struct {
        bit reuse;
        int gap;
        int mode;
        int exp_poly;
        int exp_pos;
    } job_t;

    job_t jobs[6];

    task automatic clear_counts();
        poly_idx = 0; pos_idx = 0; res_idx = 0;
        pw_cnt = 0; qw_cnt = 0; starts = 0; hold = 0;
        poly_ready_seen = 0;
    endtask

    task automatic wait_cmd_ready(input int limit);
        int c;
        c = 0;
        while (!cmd_ready && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("cmd_ready_wait", 160'(cmd_ready), 160'(1));
    endtask

    task automatic run_job(input job_t j);
        int bad;
        wait_cmd_ready(500);
        @(posedge clk); #1;
        clear_counts();
        gap_pct   = j.gap;
        rmode     = j.mode;
        drive_en  = 1'b1;
        cmd_valid = 1'b1;
        cmd_reuse = j.reuse;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_reuse = 1'b0;
        @(negedge clk);
        chk("busy_in_job", 160'(busy), 160'(1));
        chk("cmd_ready_in_job", 160'(cmd_ready), 160'(0));
        for (int c = 0; c < 8000 && res_idx < RES_WORDS; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        drive_en = 1'b0;
        chk("res_count", 160'(res_idx), 160'(RES_WORDS));
        chk("poly_writes", 160'(pw_cnt), 160'(j.exp_poly));
        chk("pos_writes", 160'(qw_cnt), 160'(j.exp_pos));
        chk("start_pulses", 160'(starts), 160'(1));
        chk("poly_ready_seen", 160'(poly_ready_seen), 160'(j.exp_poly != 0));
        chk("idle_after_job", 160'(cmd_ready), 160'(1));
        if (j.mode == 0) chk("no_bubble_span", 160'(last_acc - first_acc), 160'(RES_WORDS - 1));
        bad = 0;
        for (int i = 0; i < POLY_WORDS; i++) if (poly_ram[i] !== poly_word(i)) bad++;
        chk("poly_ram_contents_bad", 160'(bad), 160'(0));
        bad = 0;
        for (int i = 0; i < POS_DEPTH; i++) if (pos_ram[i] !== pos_word(i)) bad++;
        chk("pos_ram_contents_bad", 160'(bad), 160'(0));
`ifdef SPM_CYCLE_CNT_EN
        chk("cycle_cnt", 160'(cycle_cnt), 160'(31));
`endif
    endtask

    // One reset edge, then verify reset outputs, quiet guard period and that done is ignored.
    task automatic apply_reset();
        int  n;
        bit  noisy;
        @(posedge clk); #1;
        rst = 1'b1;
        drive_en  = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        noisy = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("rst_cmd_ready", 160'(cmd_ready), 160'(0));
                chk("rst_busy", 160'(busy), 160'(1));
                chk("rst_poly_ready", 160'(poly_ready), 160'(0));
                chk("rst_pos_ready", 160'(pos_ready), 160'(0));
                chk("rst_mul_start", 160'(mul_start), 160'(0));
                chk("rst_res_valid", 160'(res_valid), 160'(0));
                chk("rst_res_data", 160'(res_data), 160'(0));
                chk("rst_rd_en", 160'(mul_res_rd_en), 160'(0));
                chk("rst_poly_wr", 160'(mul_poly_wr_en), 160'(0));
                chk("rst_pos_wr", 160'(mul_pos_wr_en), 160'(0));
`ifdef SPM_CYCLE_CNT_EN
                chk("rst_cycle_cnt", 160'(cycle_cnt), 160'(0));
`endif
            end
            if (c == 3) stray_done = 1'b1;
            if (c == 4) stray_done = 1'b0;
            if (cmd_ready) break;
            n++;
            if (mul_res_rd_en || res_valid || mul_start || poly_ready || pos_ready) noisy = 1;
        end
        chk("guard_length", 160'(n), 160'(GUARD));
        chk("quiet_during_guard", 160'(noisy), 160'(0));
    endtask

    initial begin
        jobs[0] = '{reuse: 1, gap: 0,  mode: 0, exp_poly: POLY_WORDS, exp_pos: POS_DEPTH};
        jobs[1] = '{reuse: 0, gap: 50, mode: 1, exp_poly: POLY_WORDS, exp_pos: POS_DEPTH};
        jobs[2] = '{reuse: 1, gap: 0,  mode: 2, exp_poly: 0,          exp_pos: POS_DEPTH};
        jobs[3] = '{reuse: 0, gap: 50, mode: 3, exp_poly: POLY_WORDS, exp_pos: POS_DEPTH};
        jobs[4] = '{reuse: 1, gap: 30, mode: 3, exp_poly: 0,          exp_pos: POS_DEPTH};
        jobs[5] = '{reuse: 1, gap: 20, mode: 0, exp_poly: POLY_WORDS, exp_pos: POS_DEPTH};

        apply_reset();
        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Reset while the multiplier is running: the late done must not leak through.
        wait_cmd_ready(500);
        @(posedge clk); #1;
        clear_counts();
        gap_pct = 0; rmode = 0; drive_en = 1'b1;
        cmd_valid = 1'b1; cmd_reuse = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_reuse = 1'b0;
        for (int c = 0; c < 300 && starts == 0; c++) @(negedge clk);
        chk("midjob_start_seen", 160'(starts), 160'(1));
        repeat (5) @(negedge clk);
        apply_reset();
        chk("midjob_no_drain", 160'(res_idx), 160'(0));

        // poly_loaded was cleared by reset, so reuse must reload the poly.
        run_job(jobs[5]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
